// File: rtl/dht11_frame_decoder_if.sv
// Link between the frame decoder (master) and the DHT11 bus driver (slave):
// start/enable controls out, frame and status flags back.
interface dht11_frame_decoder_if;
  logic        drv_en;
  logic        drv_rst;
  logic [39:0] drv_data;
  logic        drv_wait;
  logic        drv_error;

  modport master (
    output drv_en,
    output drv_rst,
    input  drv_data,
    input  drv_wait,
    input  drv_error
  );

  modport slave (
    input  drv_en,
    input  drv_rst,
    output drv_data,
    output drv_wait,
    output drv_error
  );
endinterface

// File: rtl/dht11_frame_decoder.sv
// Sequences DHT11 driver measurements, validates the frame checksum and retries on failure.
// Optional periodic auto-start enabled by defining DHT11_AUTO_POLL_EN.
module dht11_frame_decoder #(
  parameter int unsigned RST_CYCLES      = 4,
  parameter int unsigned ARM_TIMEOUT     = 1000,
  parameter int unsigned WATCHDOG_CYCLES = 5000000,
  parameter int unsigned RETRY_GAP       = 50000000,
  parameter int unsigned MAX_RETRIES     = 2
`ifdef DHT11_AUTO_POLL_EN
  ,
  parameter int unsigned POLL_CYCLES     = 100000000
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  dht11_frame_decoder_if.master         drv,
  output logic                          busy,
  output logic                          valid,
  output logic [1:0]                    status,
  output logic [7:0]                    hum_int,
  output logic [7:0]                    hum_dec,
  output logic [7:0]                    temp_int,
  output logic [7:0]                    temp_dec,
  output logic [1:0]                    attempts
);

  localparam int unsigned Max1 = (WATCHDOG_CYCLES > RETRY_GAP) ? WATCHDOG_CYCLES : RETRY_GAP;
  localparam int unsigned Max2 = (Max1 > ARM_TIMEOUT) ? Max1 : ARM_TIMEOUT;
  localparam int unsigned Max3 = (Max2 > RST_CYCLES) ? Max2 : RST_CYCLES;
`ifdef DHT11_AUTO_POLL_EN
  localparam int unsigned CntMax = (Max3 > POLL_CYCLES) ? Max3 : POLL_CYCLES;
`else
  localparam int unsigned CntMax = Max3;
`endif
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [1:0] StatOk      = 2'b00;
  localparam logic [1:0] StatDrvErr  = 2'b01;
  localparam logic [1:0] StatCks     = 2'b10;
  localparam logic [1:0] StatTimeout = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRstPulse,
    StArm,
    StBusy,
    StCheck,
    StGap,
    StReport
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              err_q, err_d;
  logic [1:0]        status_q, status_d;
  logic [1:0]        attempts_q, attempts_d;
  logic [7:0]        hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
  logic [7:0]        temp_int_q, temp_int_d, temp_dec_q, temp_dec_d;

  logic [39:0] frame_r;
  logic [7:0]  sum;
  logic [31:0] retry_ext;
  logic [1:0]  attempts_now;
  logic        fail;
  logic [1:0]  fail_code;
  logic        poll_hit;
  logic        start;

  // drv_data[0] is the first wire bit, i.e. the MSB of the first byte.
  always_comb begin
    frame_r = '0;
    for (int k = 0; k < 40; k++) begin
      frame_r[39-k] = drv.drv_data[k];
    end
  end

  assign sum          = frame_r[39:32] + frame_r[31:24] + frame_r[23:16] + frame_r[15:8];
  assign retry_ext    = 32'(retry_q);
  assign attempts_now = (retry_ext >= 32'd2) ? 2'd3 : (retry_ext[1:0] + 2'd1);

`ifdef DHT11_AUTO_POLL_EN
  logic [CntW-1:0] poll_q, poll_d;

  assign poll_hit = (state_q == StIdle) && (poll_q == CntW'(POLL_CYCLES - 1));

  // Poll timer only advances while idle; any start or non-idle state clears it.
  always_comb begin
    poll_d = '0;
    if (state_q == StIdle && !start) begin
      poll_d = poll_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_d;
    end
  end
`else
  assign poll_hit = 1'b0;
`endif

  assign start = (state_q == StIdle) && (req || poll_hit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    err_d      = err_q;
    status_d   = status_q;
    attempts_d = attempts_q;
    hum_int_d  = hum_int_q;
    hum_dec_d  = hum_dec_q;
    temp_int_d = temp_int_q;
    temp_dec_d = temp_dec_q;
    drv.drv_en  = 1'b0;
    drv.drv_rst = 1'b0;
    fail       = 1'b0;
    fail_code  = StatOk;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          retry_d = '0;
          cnt_d   = '0;
          state_d = StRstPulse;
        end
      end
      StRstPulse: begin
        drv.drv_en  = 1'b1;
        drv.drv_rst = 1'b1;
        err_d       = 1'b0;
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StArm;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StArm: begin
        drv.drv_en = 1'b1;
        if (drv.drv_wait) begin
          cnt_d   = '0;
          state_d = StBusy;
        end else if (cnt_q == CntW'(ARM_TIMEOUT - 1)) begin
          fail      = 1'b1;
          fail_code = StatTimeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusy: begin
        drv.drv_en = 1'b1;
        // Driver drops error before wait on its error path, so latch it here.
        if (drv.drv_error) begin
          err_d = 1'b1;
        end
        if (!drv.drv_wait) begin
          state_d = StCheck;
        end else if (cnt_q == CntW'(WATCHDOG_CYCLES - 1)) begin
          fail      = 1'b1;
          fail_code = StatTimeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        drv.drv_en = 1'b1;
        if (err_q) begin
          fail      = 1'b1;
          fail_code = StatDrvErr;
        end else if (sum != frame_r[7:0]) begin
          fail      = 1'b1;
          fail_code = StatCks;
        end else begin
          hum_int_d  = frame_r[39:32];
          hum_dec_d  = frame_r[31:24];
          temp_int_d = frame_r[23:16];
          temp_dec_d = frame_r[15:8];
          status_d   = StatOk;
          attempts_d = attempts_now;
          state_d    = StReport;
        end
      end
      StGap: begin
        if (cnt_q == CntW'(RETRY_GAP - 1)) begin
          cnt_d   = '0;
          state_d = StRstPulse;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fail) begin
      if (retry_q < RetryW'(MAX_RETRIES)) begin
        retry_d = retry_q + 1'b1;
        cnt_d   = '0;
        state_d = StGap;
      end else begin
        status_d   = fail_code;
        attempts_d = attempts_now;
        state_d    = StReport;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
      status_q   <= 2'b00;
      attempts_q <= 2'b00;
      hum_int_q  <= 8'h00;
      hum_dec_q  <= 8'h00;
      temp_int_q <= 8'h00;
      temp_dec_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      status_q   <= status_d;
      attempts_q <= attempts_d;
      hum_int_q  <= hum_int_d;
      hum_dec_q  <= hum_dec_d;
      temp_int_q <= temp_int_d;
      temp_dec_q <= temp_dec_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign valid    = (state_q == StReport);
  assign status   = status_q;
  assign attempts = attempts_q;
  assign hum_int  = hum_int_q;
  assign hum_dec  = hum_dec_q;
  assign temp_int = temp_int_q;
  assign temp_dec = temp_dec_q;

endmodule

// File: doc/dht11_frame_decoder.md
Name: dht11_frame_decoder

Overview:
Sequencer and decoder directly downstream of the DHT11 bus driver. It starts a measurement on the driver by pulsing the driver's reset with enable held high, then waits for the driver's busy flag to fall. It captures the driver's error flag, bit-reverses the 40-bit frame, checks the checksum, retries on failure, and presents humidity and temperature bytes with a one-cycle valid strobe and a status code.

Parameters:
RST_CYCLES, 4, cycles drv_rst is held high per attempt (min 1)
ARM_TIMEOUT, 1000, max cycles from drv_rst fall to drv_wait rise
WATCHDOG_CYCLES, 5000000, max cycles drv_wait may stay high (100 ms at 50 MHz)
RETRY_GAP, 50000000, idle cycles between attempts (1 s at 50 MHz, sensor minimum)
MAX_RETRIES, 2, extra attempts after the first failure (0 = single attempt)

Ports:
clk  in  1  clock, 50 MHz
rst  in  1  reset
req  in  1  start request, sampled in IDLE only
drv_en  out  1  enable to driver
drv_rst  out  1  reset/start pulse to driver
drv_data  in  40  driver frame; drv_data[0] = first bit on the wire
drv_wait  in  1  driver busy flag
drv_error  in  1  driver error flag
busy  out  1  high whenever state != IDLE
valid  out  1  one-cycle strobe; outputs below are stable from this cycle on
status  out  2  00 OK, 01 DRV_ERROR, 10 CHECKSUM, 11 TIMEOUT
hum_int, hum_dec, temp_int, temp_dec  out  8 each  decoded fields, updated only on OK
attempts  out  2  attempts used in the last reported transaction (1..MAX_RETRIES+1, saturating at 3)

Behaviour:
- Reset is clk and rst, synchronous, active-high. On reset, every output is 0, state is IDLE, and the sticky error, counters and retry count are cleared. Reset mid-transaction aborts it immediately with no valid pulse. drv_en=0 releases the driver (frozen).
- IDLE: drv_en=0, drv_rst=0. req=1 causes retry_cnt<=0 and a move to RST_PULSE. req is ignored in all other states; a req pulse that is not seen in IDLE is lost.
- RST_PULSE: drv_en=1, drv_rst=1 for RST_CYCLES cycles. Clears err_sticky and the counter. Moves to ARM.
- ARM: drv_en=1, drv_rst=0. drv_wait=1 causes counter<=0 and a move to BUSY. If ARM_TIMEOUT cycles pass first, the failure is TIMEOUT.
- BUSY: drv_en=1. Any cycle with drv_error=1 sets err_sticky. The driver drops error before wait on its error path, so the flag must be sticky. drv_wait=0 causes a move to CHECK. Reaching WATCHDOG_CYCLES is a TIMEOUT failure.
- CHECK (1 cycle): r[39-k]=drv_data[k]. Fields are hum_int=r[39:32], hum_dec=r[31:24], temp_int=r[23:16], temp_dec=r[15:8], cks=r[7:0].
  - err_sticky=1 gives a DRV_ERROR failure; this takes priority over the checksum.
  - Otherwise, the checksum passes when the 8-bit wrapping sum of the four bytes equals cks. On a pass, the field outputs are loaded and the result is OK. On a mismatch, the failure is CHECKSUM.
- Failure handling: if retry_cnt<MAX_RETRIES, retry_cnt++ and move to GAP. Otherwise move to REPORT with that code.
- GAP: drv_en=0. Wait RETRY_GAP cycles, then RST_PULSE.
- REPORT (1 cycle): valid=1, status=code, attempts=retry_cnt+1, then IDLE. On failure, the field outputs keep their previous values.
- Latency on success, first attempt: RST_CYCLES + (cycles to drv_wait rise) + (drv_wait high time) + 2 cycles (CHECK, REPORT).
- All frame bytes are 0 → checksum 0 = pass. This is still reported OK; the decoder does not judge plausibility.
- Counters must be wide enough for max(WATCHDOG_CYCLES, RETRY_GAP, POLL_CYCLES) without wrap-around.

Optional Feature:
Macro DHT11_AUTO_POLL_EN.
- Defined: adds parameter POLL_CYCLES, default 100000000. A free-running poll timer counts in IDLE only. On reaching POLL_CYCLES it starts a transaction exactly as req does, then clears. Any transaction start, manual or automatic, clears it. req keeps working.
- Undefined: no poll timer and no POLL_CYCLES logic. The block starts only on req.

Test Plan:
- Use a driver model. req pulse; model raises wait 3 cycles after drv_rst falls, holds it 2000 cycles, returns wire bytes 0x37,0x00,0x19,0x00,0x50. Required: valid once, status=00, hum_int=0x37, temp_int=0x19, attempts=1, busy falls the cycle after valid.
- Same stimulus, but the checksum byte is 0x51 on every attempt (MAX_RETRIES=2, small RETRY_GAP). Required: 3 drv_rst pulses, each RST_CYCLES long; valid once with status=10 and attempts=3; field outputs unchanged from the previous OK.
- Model pulses drv_error for 1 cycle, drops it, then drops wait 100 cycles later. Frame has a valid checksum. Required: status=01, not OK; retried.
- Model never raises wait. Required: TIMEOUT after ARM_TIMEOUT cycles per attempt; final status=11.
- Assert rst mid-BUSY. Required: next cycle busy=0, drv_en=0, drv_rst=0, no valid pulse. Also: req held high during BUSY starts no second transaction.
- With DHT11_AUTO_POLL_EN defined and POLL_CYCLES=500: no req applied. Required: drv_rst rises 500 cycles after reset release, and again 500 IDLE cycles after each REPORT.
